axis_fifo_hs: RTL and testbench



---
 rtl/axis_fifo_hs.sv | 135 +++++++++++++
 tb/tb_axis_fifo_hs.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_hs.sv
// rtl/axis_fifo_hs.sv - AXI-stream FIFO with registered output slot, fill level and sticky overflow.
// Optional packet mode under `AXIS_FIFO_PACKET_MODE_EN`.
module axis_fifo_hs #(
  parameter int DATA_WIDTH         = 32,
  parameter int USER_WIDTH         = 32,
  parameter int DEST_WIDTH         = 32,
  parameter int FIFO_DEPTH         = 16,
  parameter int ALMOST_FULL_LEVEL  = FIFO_DEPTH - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         in_tdata_i,
  input  logic [USER_WIDTH-1:0]         in_tuser_i,
  input  logic [DEST_WIDTH-1:0]         in_tdest_i,
  input  logic                          in_tlast_i,
  input  logic                          in_tvalid_i,
  output logic                          in_tready_o,
  output logic [DATA_WIDTH-1:0]         out_tdata_o,
  output logic [USER_WIDTH-1:0]         out_tuser_o,
  output logic [DEST_WIDTH-1:0]         out_tdest_o,
  output logic                          out_tlast_o,
  output logic                          out_tvalid_o,
  input  logic                          out_tready_i,
  input  logic                          clear_flags_i,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level_o,
  output logic                          almost_full_o,
  output logic                          almost_empty_o,
  output logic                          overflow_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = 1 + DATA_WIDTH + USER_WIDTH + DEST_WIDTH;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] AFULL_L = (AW+1)'(ALMOST_FULL_LEVEL);
  localparam logic [AW:0] AEMPTY_L = (AW+1)'(ALMOST_EMPTY_LEVEL);

  // Memory spans the full depth so packet mode can hold FIFO_DEPTH beats with the slot empty.
  logic [BW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d, mem_count;
  logic          out_valid_q, out_valid_d;
  logic [BW-1:0] out_beat_q, out_beat_d;
  logic          overflow_q, overflow_d;
  logic [BW-1:0] head, beat_in;
  logic          push, pop, load, load_ok;

  assign in_tready_o = reset & (fill_q < DEPTH_L);
  assign beat_in     = {in_tlast_i, in_tdata_i, in_tuser_i, in_tdest_i};
  assign head        = mem_q[rd_ptr_q];
  assign mem_count   = fill_q - {{AW{1'b0}}, out_valid_q};

`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic [AW:0] pkt_cnt_q, pkt_cnt_d;
  logic        release_q, release_d;

  // pkt_cnt counts tlast beats still in memory; release lets an oversized packet drain.
  always_comb begin
    load_ok   = (pkt_cnt_q != '0) | release_q | (fill_q == DEPTH_L);
    pkt_cnt_d = pkt_cnt_q;
    if (push & in_tlast_i)   pkt_cnt_d = pkt_cnt_d + 1'b1;
    if (load & head[BW-1])   pkt_cnt_d = pkt_cnt_d - 1'b1;
    release_d = release_q;
    if (load & head[BW-1])                              release_d = 1'b0;
    else if ((fill_q == DEPTH_L) && (pkt_cnt_q == '0))  release_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pkt_cnt_q <= '0;
      release_q <= 1'b0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      release_q <= release_d;
    end
  end
`else
  assign load_ok = 1'b1;
`endif

  always_comb begin
    push = in_tvalid_i & in_tready_o;
    pop  = out_valid_q & out_tready_i;
    load = load_ok & (mem_count != '0) & (~out_valid_q | pop);

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = load ? rd_ptr_q + 1'b1 : rd_ptr_q;

    fill_d = fill_q;
    if (push & ~pop)      fill_d = fill_q + 1'b1;
    else if (~push & pop) fill_d = fill_q - 1'b1;

    out_valid_d = out_valid_q;
    out_beat_d  = out_beat_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_beat_d  = head;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end

    overflow_d = (in_tvalid_i & ~in_tready_o) | (overflow_q & ~clear_flags_i);
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= beat_in;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_beat_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_beat_q  <= out_beat_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_tvalid_o   = out_valid_q;
  assign out_tlast_o    = out_beat_q[BW-1];
  assign out_tdata_o    = out_beat_q[BW-2 -: DATA_WIDTH];
  assign out_tuser_o    = out_beat_q[DEST_WIDTH +: USER_WIDTH];
  assign out_tdest_o    = out_beat_q[DEST_WIDTH-1:0];
  assign fill_level_o   = fill_q;
  assign almost_full_o  = fill_q >= AFULL_L;
  assign almost_empty_o = fill_q <= AEMPTY_L;
  assign overflow_o     = overflow_q;
endmodule

// File: tb/tb_axis_fifo_hs.sv
// tb/tb_axis_fifo_hs.sv - randomized self-checking bench for axis_fifo_hs against a queue model.
module tb_axis_fifo_hs;
  localparam int DEPTH = 16;
  typedef logic [96:0] beat_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [31:0] in_tdata, in_tuser, in_tdest;
  logic        in_tlast, in_tvalid, in_tready;
  logic [31:0] out_tdata, out_tuser, out_tdest;
  logic        out_tlast, out_tvalid, out_tready;
  logic        clear_flags;
  logic [4:0]  fill_level;
  logic        almost_full, almost_empty, overflow;
  beat_t       dut_beat;

  int tests = 0, failed = 0;

  beat_t mdl_q[$];
  bit    mdl_ovf = 0;
  int    mdl_fresh = 0;
  bit    got_pop, last_push;
  beat_t got_beat, exp_beat;

  axis_fifo_hs dut (
    .clock(clock), .reset(reset),
    .in_tdata_i(in_tdata), .in_tuser_i(in_tuser), .in_tdest_i(in_tdest),
    .in_tlast_i(in_tlast), .in_tvalid_i(in_tvalid), .in_tready_o(in_tready),
    .out_tdata_o(out_tdata), .out_tuser_o(out_tuser), .out_tdest_o(out_tdest),
    .out_tlast_o(out_tlast), .out_tvalid_o(out_tvalid), .out_tready_i(out_tready),
    .clear_flags_i(clear_flags), .fill_level_o(fill_level),
    .almost_full_o(almost_full), .almost_empty_o(almost_empty), .overflow_o(overflow)
  );

  assign dut_beat = {out_tlast, out_tdata, out_tuser, out_tdest};

  function automatic beat_t mk(input logic last, input logic [31:0] d, input logic [31:0] u,
                               input logic [31:0] t);
    return {last, d, u, t};
  endfunction

  // A beat is visible once it has spent one full cycle inside the FIFO.
  function automatic bit mdl_vis();
    return (mdl_q.size() - mdl_fresh) > 0;
  endfunction

  task automatic tick();
    bit pushing, popping;
    pushing  = reset && in_tvalid && (mdl_q.size() < DEPTH);
    popping  = reset && out_tready && mdl_vis();
    got_pop  = popping;
    got_beat = dut_beat;
    if (popping) exp_beat = mdl_q[0];
    last_push = pushing;
    @(posedge clock);
    if (!reset) begin
      mdl_q.delete();
      mdl_ovf   = 0;
      mdl_fresh = 0;
    end else begin
      if (in_tvalid && mdl_q.size() >= DEPTH) mdl_ovf = 1;
      else if (clear_flags)                   mdl_ovf = 0;
      if (popping) void'(mdl_q.pop_front());
      if (pushing) mdl_q.push_back(mk(in_tlast, in_tdata, in_tuser, in_tdest));
      mdl_fresh = pushing ? 1 : 0;
    end
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] d, input logic last);
    in_tvalid = v;
    in_tdata  = d;
    in_tuser  = ~d;
    in_tdest  = {28'd0, d[3:0]};
    in_tlast  = last;
  endtask

  task automatic drain();
    set_in(1'b0, 32'd0, 1'b0);
    out_tready = 1'b1;
    for (int i = 0; i < 40 && (mdl_q.size() > 0 || out_tvalid); i++) tick();
    out_tready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_flags = 1'b0;
    out_tready = 1'b0;
    set_in(1'b1, 32'hDEAD_BEEF, 1'b1);
    tick();
    tick();
    tests++; if (in_tready !== 1'b0) begin failed++; $display("FAIL reset_in_ready got=%b exp=0", in_tready); end
    tests++; if (out_tvalid !== 1'b0) begin failed++; $display("FAIL reset_out_valid got=%b exp=0", out_tvalid); end
    tests++; if (dut_beat !== '0) begin failed++; $display("FAIL reset_out_beat got=%h exp=0", dut_beat); end
    tests++; if (fill_level !== 5'd0) begin failed++; $display("FAIL reset_fill got=%0d exp=0", fill_level); end
    tests++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin
      failed++; $display("FAIL reset_almost got ae=%b af=%b exp ae=1 af=0", almost_empty, almost_full); end
    tests++; if (overflow !== 1'b0) begin failed++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    set_in(1'b0, 32'd0, 1'b0);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int pops = 0;
    out_tready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 3) set_in(1'b1, 32'h11 * (i + 1), i == 2);
      else       set_in(1'b0, 32'd0, 1'b0);
      tests++; if (out_tvalid !== mdl_vis()) begin
        failed++; $display("FAIL basic_valid cyc=%0d got=%b exp=%b", i, out_tvalid, mdl_vis()); end
      tick();
      if (i == 0) begin
        tests++; if (out_tvalid !== 1'b0) begin failed++; $display("FAIL basic_latency0 got=%b exp=0", out_tvalid); end
      end
      if (i == 1) begin
        tests++; if (out_tvalid !== 1'b1 || out_tdata !== 32'h11) begin
          failed++; $display("FAIL basic_latency1 got v=%b d=%h exp v=1 d=11", out_tvalid, out_tdata); end
      end
      if (got_pop) begin
        pops++;
        tests++; if (got_beat !== exp_beat) begin
          failed++; $display("FAIL basic_order got=%h exp=%h", got_beat, exp_beat); end
      end
    end
    tests++; if (pops !== 3) begin failed++; $display("FAIL basic_count got=%0d exp=3", pops); end
    tests++; if (fill_level !== 5'd0 || almost_empty !== 1'b1) begin
      failed++; $display("FAIL basic_empty got fill=%0d ae=%b exp fill=0 ae=1", fill_level, almost_empty); end
    out_tready = 1'b0;
  endtask

  task automatic test_full();
    out_tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, i, 1'b0);
      tests++; if (in_tready !== 1'b1) begin failed++; $display("FAIL full_ready_before i=%0d got=%b exp=1", i, in_tready); end
      tick();
    end
    set_in(1'b0, 32'd0, 1'b0);
    tests++; if (fill_level !== 5'd16 || in_tready !== 1'b0 || almost_full !== 1'b1) begin
      failed++; $display("FAIL full_state got fill=%0d rdy=%b af=%b exp 16/0/1", fill_level, in_tready, almost_full); end
    tests++; if (overflow !== 1'b0) begin failed++; $display("FAIL full_no_ovf got=%b exp=0", overflow); end
    set_in(1'b1, 32'd16, 1'b0);
    tick();
    set_in(1'b0, 32'd0, 1'b0);
    tests++; if (overflow !== 1'b1 || overflow !== mdl_ovf || fill_level !== 5'd16) begin
      failed++; $display("FAIL full_ovf_set got ovf=%b fill=%0d exp ovf=1 fill=16", overflow, fill_level); end
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    tests++; if (overflow !== 1'b0) begin failed++; $display("FAIL full_ovf_clear got=%b exp=0", overflow); end
    clear_flags = 1'b1; set_in(1'b1, 32'd17, 1'b0); tick();
    clear_flags = 1'b0; set_in(1'b0, 32'd0, 1'b0);
    tests++; if (overflow !== 1'b1) begin failed++; $display("FAIL full_set_wins got=%b exp=1", overflow); end
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    out_tready = 1'b1; tick(); out_tready = 1'b0;
    tests++; if (in_tready !== 1'b1 || fill_level !== 5'd15 || got_beat !== exp_beat) begin
      failed++; $display("FAIL full_pop_ready got rdy=%b fill=%0d beat=%h exp rdy=1 fill=15 beat=%h",
                         in_tready, fill_level, got_beat, exp_beat); end
    set_in(1'b1, 32'h100, 1'b1); tick(); set_in(1'b0, 32'd0, 1'b0);
  endtask

  task automatic test_random();
    int sent = 0, pops = 0, cyc = 0;
    while (cyc < 3000 && !(sent == 100 && mdl_q.size() == 0)) begin
      set_in((sent < 100) && ($urandom_range(0, 3) != 0), 32'h2000 + sent, $urandom_range(0, 1));
      out_tready = $urandom_range(0, 1);
      tests++; if (in_tready !== (mdl_q.size() < DEPTH)) begin
        failed++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, in_tready, mdl_q.size() < DEPTH); end
      tests++; if (out_tvalid !== mdl_vis()) begin
        failed++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, out_tvalid, mdl_vis()); end
      tick();
      if (last_push) sent++;
      if (got_pop) begin
        pops++;
        tests++; if (got_beat !== exp_beat) begin
          failed++; $display("FAIL rnd_beat cyc=%0d got=%h exp=%h", cyc, got_beat, exp_beat); end
      end
      tests++; if (fill_level !== 5'(mdl_q.size())) begin
        failed++; $display("FAIL rnd_fill cyc=%0d got=%0d exp=%0d", cyc, fill_level, mdl_q.size()); end
      cyc++;
    end
    set_in(1'b0, 32'd0, 1'b0);
    out_tready = 1'b0;
    tests++; if (sent != 100 || pops != 116) begin
      failed++; $display("FAIL rnd_complete got sent=%0d pops=%0d exp 100/116", sent, pops); end
  endtask

  task automatic test_simultaneous();
    drain();
    for (int i = 0; i < 5; i++) begin set_in(1'b1, 32'h300 + i, 1'b0); tick(); end
    set_in(1'b0, 32'd0, 1'b0);
    tick();
    set_in(1'b1, 32'h305, 1'b1);
    out_tready = 1'b1;
    tick();
    set_in(1'b0, 32'd0, 1'b0);
    tests++; if (fill_level !== 5'd5 || !got_pop || got_beat !== exp_beat) begin
      failed++; $display("FAIL simul_fill got fill=%0d beat=%h exp fill=5 beat=%h", fill_level, got_beat, exp_beat); end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (got_pop) begin
        tests++; if (got_beat !== exp_beat) begin
          failed++; $display("FAIL simul_order got=%h exp=%h", got_beat, exp_beat); end
      end
    end
    out_tready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    drain();
    for (int i = 0; i < 7; i++) begin set_in(1'b1, 32'h400 + i, 1'b1); tick(); end
    set_in(1'b0, 32'd0, 1'b0);
    reset = 1'b0;
    tick();
    tests++; if (out_tvalid !== 1'b0 || fill_level !== 5'd0 || in_tready !== 1'b0) begin
      failed++; $display("FAIL rstmid_state got v=%b fill=%0d rdy=%b exp 0/0/0", out_tvalid, fill_level, in_tready); end
    reset = 1'b1;
    out_tready = 1'b1;
    set_in(1'b1, 32'hAA, 1'b0);
    tick();
    set_in(1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 5 && !seen; i++) begin
      if (out_tvalid) begin
        seen = 1;
        tests++; if (out_tdata !== 32'hAA) begin failed++; $display("FAIL rstmid_first got=%h exp=aa", out_tdata); end
      end
      tick();
    end
    tests++; if (!seen) begin failed++; $display("FAIL rstmid_timeout got=none exp=aa"); end
    out_tready = 1'b0;
  endtask

  task automatic test_packet();
    int n = 0;
    out_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h500 + i, i == 2);
      tick();
      tests++; if (out_tvalid !== 1'b0) begin failed++; $display("FAIL pkt_hold i=%0d got=%b exp=0", i, out_tvalid); end
    end
    set_in(1'b0, 32'd0, 1'b0);
    for (int c = 0; c < 10 && n < 3; c++) begin
      tick();
      if (out_tvalid) begin
        tests++; if (out_tdata !== 32'h500 + n || out_tlast !== (n == 2)) begin
          failed++; $display("FAIL pkt_stream n=%0d got=%h exp=%h", n, out_tdata, 32'h500 + n); end
        n++;
      end
    end
    tests++; if (n != 3) begin failed++; $display("FAIL pkt_count got=%0d exp=3", n); end
    drain();
    out_tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin set_in(1'b1, 32'h600 + i, 1'b0); tick(); end
    set_in(1'b0, 32'd0, 1'b0);
    tests++; if (fill_level !== 5'd16) begin failed++; $display("FAIL pkt_full got=%0d exp=16", fill_level); end
    tick();
    out_tready = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < DEPTH; c++) begin
      if (out_tvalid) begin
        tests++; if (out_tdata !== 32'h600 + n) begin
          failed++; $display("FAIL pkt_release n=%0d got=%h exp=%h", n, out_tdata, 32'h600 + n); end
        n++;
      end
      tick();
    end
    tests++; if (n != DEPTH) begin failed++; $display("FAIL pkt_release_count got=%0d exp=16", n); end
  endtask

  initial begin
    test_reset();
`ifdef AXIS_FIFO_PACKET_MODE_EN
    test_packet();
`else
    test_basic();
    test_full();
    test_random();
    test_simultaneous();
    test_reset_mid();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
